// File: rtl/sonar_pkg.sv
// Shared sonar definitions: FSM states, default widths and a saturating
// absolute-value helper reused by other sonar stages.
package sonar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_LISTEN,
    ST_REPORT
  } state_e;

  localparam int DATA_W_DEF = 21;
  localparam int CNT_W_DEF  = 16;

  // x is the sample sign-extended to 32 bits, w its native width (w < 32).
  // The most-negative input maps onto the largest positive value.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] x, input int w);
    logic [32:0] ax;
    logic [32:0] lim;
    lim = (33'd1 << (w - 1)) - 33'd1;
    ax  = x[31] ? (33'd0 - {1'b1, x}) : {1'b0, x};
    return (ax > lim) ? lim[31:0] : ax[31:0];
  endfunction

endpackage

// File: rtl/abs_envelope.sv
// Rectifier plus leaky integrator: env += (|x| - env) >>> ENV_SHIFT, clamped
// to the positive DATA_W range. env_next exposes the value about to be stored.
module abs_envelope
  import sonar_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ENV_SHIFT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] env,
  output logic [DATA_W-1:0] env_next
);

  localparam logic [DATA_W+1:0] MAXV = {3'b000, {(DATA_W-1){1'b1}}};

  logic [DATA_W-1:0]        env_q, env_d;
  logic signed [31:0]       ext;
  logic [31:0]              abs_w;
  logic [DATA_W+1:0]        mag, env_ext;
  logic signed [DATA_W+1:0] diff, sum;
  logic                     unused_abs_hi;

  assign unused_abs_hi = ^abs_w[31:DATA_W];

  always_comb begin
    ext     = {{(32-DATA_W){in[DATA_W-1]}}, in};
    abs_w   = sat_abs(ext, DATA_W);
    mag     = {2'b00, abs_w[DATA_W-1:0]};
    env_ext = {2'b00, env_q};
    diff    = $signed(mag) - $signed(env_ext);
    sum     = $signed(env_ext) + (diff >>> ENV_SHIFT);
    if (sum < 0)
      env_next = '0;
    else if (sum > $signed(MAXV))
      env_next = MAXV[DATA_W-1:0];
    else
      env_next = sum[DATA_W-1:0];

    env_d = env_q;
    if (clear)
      env_d = '0;
    else if (in_valid)
      env_d = env_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) env_q <= '0;
    else       env_q <= env_d;
  end

  assign env = env_q;

endmodule

// File: rtl/echo_tof_detector.sv
// Sonar time-of-flight detector: blanks the direct path after a ping, then
// reports the sample index of the first echo held above threshold HOLD_N times.
module echo_tof_detector
  import sonar_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int BLANK_N   = 64,
  parameter int MAX_N     = 4000,
  parameter int ENV_SHIFT = 3,
  parameter int HOLD_N    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ping_start,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] threshold,
  output logic [DATA_W-1:0] envelope,
  output logic              busy,
  output logic [CNT_W-1:0]  tof_count,
  output logic              tof_valid,
  output logic              timeout
);

  localparam int HOLD_W = $clog2(HOLD_N + 1);
  localparam logic [CNT_W-1:0]  BLANK_C = CNT_W'(BLANK_N);
  localparam logic [CNT_W-1:0]  MAX_C   = CNT_W'(MAX_N);
  localparam logic [CNT_W-1:0]  ONES    = '1;
  localparam logic [HOLD_W-1:0] HOLD_C  = HOLD_W'(HOLD_N);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [HOLD_W-1:0]  hold_q, hold_d, hold_nx;
  logic [DATA_W-1:0]  thr_q, thr_d;
  logic [CNT_W-1:0]   tof_q, tof_d;
  logic               hit_q, hit_d;
  logic               env_clear, env_valid;
  logic [DATA_W-1:0]  env_next;

  // The sample that coincides with a ping belongs to no measurement.
  assign env_valid = sample_valid & ~ping_start;

  abs_envelope #(
    .DATA_W    (DATA_W),
    .ENV_SHIFT (ENV_SHIFT)
  ) u_env (
    .clk      (clk),
    .reset    (reset),
    .clear    (env_clear),
    .in_valid (env_valid),
    .in       (sample_in),
    .env      (envelope),
    .env_next (env_next)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    thr_d     = thr_q;
    tof_d     = tof_q;
    hit_d     = hit_q;
    env_clear = 1'b0;
    cnt_inc   = (cnt_q == ONES) ? cnt_q : cnt_q + 1'b1;
    hold_nx   = (env_next >= thr_q) ? hold_q + 1'b1 : '0;

    if (ping_start) begin
      state_d = ST_BLANK;
      cnt_d   = '0;
      hold_d  = '0;
      thr_d   = threshold;
    end else begin
      case (state_q)
        ST_BLANK: if (sample_valid) begin
          cnt_d = cnt_inc;
          if (cnt_inc == BLANK_C) begin
            env_clear = 1'b1;
            hold_d    = '0;
            state_d   = ST_LISTEN;
          end
        end
        ST_LISTEN: if (sample_valid) begin
          cnt_d  = cnt_inc;
          hold_d = hold_nx;
          // A confirming sample beats a simultaneous timeout.
          if (hold_nx == HOLD_C) begin
            state_d = ST_REPORT;
            hit_d   = 1'b1;
            tof_d   = cnt_inc;
          end else if (cnt_inc >= MAX_C) begin
            state_d = ST_REPORT;
            hit_d   = 1'b0;
            tof_d   = ONES;
          end
        end
        ST_REPORT: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      thr_q   <= '0;
      tof_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      thr_q   <= thr_d;
      tof_q   <= tof_d;
      hit_q   <= hit_d;
    end
  end

  assign busy      = (state_q == ST_BLANK) || (state_q == ST_LISTEN);
  assign tof_valid = (state_q == ST_REPORT) &&  hit_q;
  assign timeout   = (state_q == ST_REPORT) && !hit_q;
  assign tof_count = tof_q;

endmodule
